// File: rtl/fpu_result_wb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : fpu_result_wb_if                                             |
// | Purpose   : Valid/ready result bus carrying an FP result, its            |
// |             destination register and its 4-bit exception code.           |
// |             The master drives valid/data/rd/exc. The slave drives ready. |
// | Signals   : valid  - entry valid this cycle                              |
// |             ready  - receiver accepts the entry                          |
// |             data   - 32-bit IEEE-754 single result                       |
// |             rd     - destination FP register (RD_W bits)                 |
// |             exc    - FPU exception code                                  |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface fpu_result_wb_if #(
  parameter int RD_W = 5
) ();

  logic            valid;
  logic            ready;
  logic [31:0]     data;
  logic [RD_W-1:0] rd;
  logic [3:0]      exc;

  modport master (
    output valid,
    output data,
    output rd,
    output exc,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  rd,
    input  exc,
    output ready
  );

endinterface
`default_nettype wire

// File: rtl/fpu_result_wb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fpu_result_wb                                                 |
// | Purpose  : FPU writeback stage. It queues FPU results with their         |
// |            destination and exception code in a small FIFO. It presents   |
// |            the head entry to the FP register-file write port and         |
// |            accumulates sticky RISC-V fflags as entries retire.           |
// | Ports    : clk_i        - clock, rising edge                             |
// |            rst_ni       - synchronous reset, active-low                  |
// |            in_bus       - slave result bus from the FPU datapath         |
// |                           (in_bus.ready = !full)                         |
// |            wb_bus       - master result bus to the register file         |
// |                           (wb_bus.valid = !empty)                        |
// |            flush_i      - discard every queued entry                     |
// |            fflags_clr_i - clear sticky flags (CSR write)                 |
// |            fflags_o     - sticky {NV,DZ,OF,UF,NX}                        |
// |            count_o      - occupancy, 0..DEPTH                            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fpu_result_wb #(
  parameter int DEPTH = 2,   // power of two, >= 2
  parameter int RD_W  = 5
) (
  input  wire logic                   clk_i,
  input  wire logic                   rst_ni,
  fpu_result_wb_if.slave              in_bus,
  fpu_result_wb_if.master             wb_bus,
  input  wire logic                   flush_i,
  input  wire logic                   fflags_clr_i,
  output logic [4:0]                  fflags_o,
  output logic [$clog2(DEPTH):0]      count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

  // Flag bit positions within {NV,DZ,OF,UF,NX}
  localparam logic [4:0] C_NV = 5'b10000;
  localparam logic [4:0] C_DZ = 5'b01000;
  localparam logic [4:0] C_OF = 5'b00100;
  localparam logic [4:0] C_UF = 5'b00010;
  localparam logic [4:0] C_NX = 5'b00001;

  // Entry storage is deliberately left unreset. Only the pointers and the
  // count qualify which entries are meaningful.
  logic [31:0]     r_data_mem [DEPTH];
  logic [RD_W-1:0] r_rd_mem   [DEPTH];
  logic [3:0]      r_exc_mem  [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [4:0]       r_fflags;

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic [3:0] w_head_exc;
  logic [4:0] w_set_flags;

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // Ready depends only on the registered count, so a full FIFO does not
  // accept a new entry in the same cycle that it retires one.
  assign w_push = in_bus.valid & ~w_full;
  assign w_pop  = wb_bus.ready & ~w_empty;

  assign w_head_exc = r_exc_mem[r_rd_ptr];

  // Decode the retiring entry's exception code into fflags bits. A flush
  // discards the handshake, so it contributes nothing.
  always_comb begin
    w_set_flags = '0;
    if (w_pop && !flush_i) begin
      case (w_head_exc)
        4'd0:    w_set_flags = '0;
        4'd1:    w_set_flags = C_NV;
        4'd2:    w_set_flags = C_NV;
        4'd3:    w_set_flags = C_OF | C_NX;
        4'd4:    w_set_flags = C_UF | C_NX;
        4'd5:    w_set_flags = C_NX;
        4'd6:    w_set_flags = C_DZ;
        default: w_set_flags = C_NV;
      endcase
    end
  end

  // Pointer, occupancy and sticky-flag state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_fflags <= '0;
    end else begin
      // The clear applies before the OR. A clear and a retire in the same
      // cycle therefore leave only the newly retired bits.
      r_fflags <= (fflags_clr_i ? 5'b00000 : r_fflags) | w_set_flags;

      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        // DEPTH is a power of two, so the pointers wrap naturally.
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + C_CNT_ONE;
          2'b01:   r_count <= r_count - C_CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry storage write port. A flushed push is never written, so no stale
  // data can reappear at the head.
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) begin
      r_data_mem[r_wr_ptr] <= in_bus.data;
      r_rd_mem[r_wr_ptr]   <= in_bus.rd;
      r_exc_mem[r_wr_ptr]  <= in_bus.exc;
    end
  end

  assign in_bus.ready = ~w_full;
  assign wb_bus.valid = ~w_empty;
  assign wb_bus.data  = r_data_mem[r_rd_ptr];
  assign wb_bus.rd    = r_rd_mem[r_rd_ptr];
  assign wb_bus.exc   = w_head_exc;
  assign fflags_o     = r_fflags;
  assign count_o      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fpu_result_wb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fpu_result_wb                                              |
// | Purpose  : Self-checking bench for fpu_result_wb. A queue-based          |
// |            scoreboard tracks every accepted result. A table of          |
// |            exception-code vectors checks the fflags mapping. Directed    |
// |            sequences cover back-pressure, flush, wrap and reset.         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fpu_result_wb;

  localparam int DEPTH = 2;
  localparam int RD_W  = 5;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       flush_i;
  logic       fflags_clr_i;
  logic [4:0] fflags_o;
  logic [1:0] count_o;

  fpu_result_wb_if #(.RD_W(RD_W)) in_bus ();
  fpu_result_wb_if #(.RD_W(RD_W)) wb_bus ();

  fpu_result_wb #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .in_bus       (in_bus),
    .wb_bus       (wb_bus),
    .flush_i      (flush_i),
    .fflags_clr_i (fflags_clr_i),
    .fflags_o     (fflags_o),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0]     data;
    logic [RD_W-1:0] rd;
    logic [3:0]      exc;
  } ent_t;

  typedef struct {
    logic [31:0]     data;
    logic [RD_W-1:0] rd;
    logic [3:0]      exc;
    logic [4:0]      exp_flags;
  } vec_t;

  ent_t       sb[$];
  logic [4:0] m_flags;
  logic       mon_en = 1'b0;
  int         n_vec  = 0;
  int         n_err  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference flag mapping, {NV,DZ,OF,UF,NX}
  function automatic logic [4:0] flag_of(input logic [3:0] e);
    case (e)
      4'd0:    return 5'b00000;
      4'd1:    return 5'b10000;
      4'd2:    return 5'b10000;
      4'd3:    return 5'b00101;
      4'd4:    return 5'b00011;
      4'd5:    return 5'b00001;
      4'd6:    return 5'b01000;
      default: return 5'b10000;
    endcase
  endfunction

  // Scoreboard: compare the settled outputs against the model mid-cycle.
  // Then advance the model by the handshakes that the next edge performs.
  always @(negedge clk_i) begin
    logic [4:0] set_b;
    logic       can_push;
    logic       do_pop;
    if (mon_en) begin
      chk("count", 64'(count_o), 64'(sb.size()));
      chk("ready", 64'(in_bus.ready), 64'(sb.size() < DEPTH));
      chk("wb_valid", 64'(wb_bus.valid), 64'(sb.size() != 0));
      chk("fflags", 64'(fflags_o), 64'(m_flags));
      if (wb_bus.valid && sb.size() != 0) begin
        chk("wb_data", 64'(wb_bus.data), 64'(sb[0].data));
        chk("wb_rd", 64'(wb_bus.rd), 64'(sb[0].rd));
        chk("wb_exc", 64'(wb_bus.exc), 64'(sb[0].exc));
      end
      set_b    = 5'b00000;
      can_push = (sb.size() < DEPTH);
      do_pop   = (sb.size() != 0) && wb_bus.ready;
      if (!rst_ni) begin
        sb.delete();
        m_flags = 5'b00000;
      end else begin
        if (flush_i) begin
          sb.delete();
        end else begin
          if (do_pop) begin
            set_b = flag_of(sb[0].exc);
            void'(sb.pop_front());
          end
          if (in_bus.valid && can_push) begin
            sb.push_back('{data: in_bus.data, rd: in_bus.rd, exc: in_bus.exc});
          end
        end
        m_flags = (fflags_clr_i ? 5'b00000 : m_flags) | set_b;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [RD_W-1:0] r, input logic [3:0] e);
    in_bus.valid = v;
    in_bus.data  = d;
    in_bus.rd    = r;
    in_bus.exc   = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[10];

  initial begin
    vecs[0] = '{32'h0000_0001, 5'd1,  4'd0,  5'b00000};
    vecs[1] = '{32'h7FC0_0000, 5'd2,  4'd1,  5'b10000};
    vecs[2] = '{32'h7FC0_0001, 5'd4,  4'd2,  5'b10000};
    vecs[3] = '{32'h7F80_0000, 5'd8,  4'd3,  5'b00101};
    vecs[4] = '{32'h0000_0010, 5'd16, 4'd4,  5'b00011};
    vecs[5] = '{32'h3EAA_AAAB, 5'd31, 4'd5,  5'b00001};
    vecs[6] = '{32'hFF80_0000, 5'd7,  4'd6,  5'b01000};
    vecs[7] = '{32'h1234_5678, 5'd9,  4'd7,  5'b10000};
    vecs[8] = '{32'h8765_4321, 5'd10, 4'd9,  5'b10000};
    vecs[9] = '{32'hDEAD_BEEF, 5'd30, 4'd15, 5'b10000};

    rst_ni        = 1'b0;
    flush_i       = 1'b0;
    fflags_clr_i  = 1'b0;
    wb_bus.ready  = 1'b0;
    drive(1'b0, 32'h0, '0, 4'h0);
    m_flags = 5'b00000;
    tick();
    tick();
    rst_ni = 1'b1;
    mon_en = 1'b1;

    // Reset state
    chk("rst_ready", 64'(in_bus.ready), 64'd1);
    chk("rst_wb_valid", 64'(wb_bus.valid), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_fflags", 64'(fflags_o), 64'd0);

    // Single result, one-cycle latency
    wb_bus.ready = 1'b1;
    drive(1'b1, 32'h3F80_0000, 5'd3, 4'd0);
    tick();
    drive(1'b0, 32'h0, '0, 4'h0);
    chk("first_valid", 64'(wb_bus.valid), 64'd1);
    chk("first_data", 64'(wb_bus.data), 64'h3F80_0000);
    chk("first_rd", 64'(wb_bus.rd), 64'd3);
    tick();
    chk("first_count", 64'(count_o), 64'd0);
    chk("first_fflags", 64'(fflags_o), 64'd0);

    // Exception-code table: clear, push one, retire it, check flags
    for (int i = 0; i < 10; i++) begin
      wb_bus.ready = 1'b1;
      fflags_clr_i = 1'b1;
      tick();
      fflags_clr_i = 1'b0;
      drive(1'b1, vecs[i].data, vecs[i].rd, vecs[i].exc);
      tick();
      drive(1'b0, 32'h0, '0, 4'h0);
      tick();
      chk($sformatf("vec%0d_fflags", i), 64'(fflags_o), 64'(vecs[i].exp_flags));
    end
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i = 1'b0;

    // Back-pressure: fill, overflow attempt, drain in order
    wb_bus.ready = 1'b0;
    drive(1'b1, 32'hA000_0001, 5'd11, 4'd0);
    tick();
    drive(1'b1, 32'hA000_0002, 5'd12, 4'd0);
    tick();
    chk("full_count", 64'(count_o), 64'd2);
    chk("full_ready", 64'(in_bus.ready), 64'd0);
    drive(1'b1, 32'hBAD0_0003, 5'd13, 4'd0);
    tick();
    drive(1'b0, 32'h0, '0, 4'h0);
    chk("ovf_count", 64'(count_o), 64'd2);
    chk("ovf_head", 64'(wb_bus.data), 64'hA000_0001);
    wb_bus.ready = 1'b1;
    tick();
    chk("drain1_ready", 64'(in_bus.ready), 64'd1);
    chk("drain1_data", 64'(wb_bus.data), 64'hA000_0002);
    tick();
    chk("drain2_count", 64'(count_o), 64'd0);

    // Flag accumulation, then a clear coinciding with a retire
    wb_bus.ready = 1'b0;
    drive(1'b1, 32'hC000_0001, 5'd1, 4'd3);
    tick();
    drive(1'b1, 32'hC000_0002, 5'd2, 4'd1);
    tick();
    drive(1'b0, 32'h0, '0, 4'h0);
    wb_bus.ready = 1'b1;
    tick();
    tick();
    chk("acc_fflags", 64'(fflags_o), 64'b10101);
    drive(1'b1, 32'hC000_0003, 5'd3, 4'd5);
    wb_bus.ready = 1'b0;
    tick();
    drive(1'b0, 32'h0, '0, 4'h0);
    wb_bus.ready = 1'b1;
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i = 1'b0;
    chk("clr_pop_fflags", 64'(fflags_o), 64'b00001);

    // Flush with a full FIFO and a concurrent push
    wb_bus.ready = 1'b0;
    drive(1'b1, 32'hD000_0001, 5'd4, 4'd6);
    tick();
    drive(1'b1, 32'hD000_0002, 5'd5, 4'd6);
    tick();
    flush_i = 1'b1;
    drive(1'b1, 32'hD000_0003, 5'd6, 4'd6);
    tick();
    flush_i = 1'b0;
    drive(1'b0, 32'h0, '0, 4'h0);
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_wb_valid", 64'(wb_bus.valid), 64'd0);
    chk("flush_fflags", 64'(fflags_o), 64'b00001);
    wb_bus.ready = 1'b1;
    tick();
    chk("flush_absent", 64'(count_o), 64'd0);

    // Streaming push+pop with pointer wrap
    wb_bus.ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'hE000_0000 + 32'(i), RD_W'(i), 4'd0);
      tick();
      chk($sformatf("stream%0d_count", i), 64'(count_o), 64'd1);
      chk($sformatf("stream%0d_data", i), 64'(wb_bus.data), 64'(32'hE000_0000 + 32'(i)));
    end
    drive(1'b0, 32'h0, '0, 4'h0);
    tick();
    chk("stream_drained", 64'(count_o), 64'd0);

    // Reset mid-stream with a full FIFO and nonzero flags
    wb_bus.ready = 1'b0;
    drive(1'b1, 32'hF000_0001, 5'd1, 4'd6);
    tick();
    drive(1'b1, 32'hF000_0002, 5'd2, 4'd6);
    tick();
    drive(1'b1, 32'hF000_0003, 5'd3, 4'd6);
    chk("pre_rst_count", 64'(count_o), 64'd2);
    rst_ni = 1'b0;
    tick();
    chk("mid_rst_ready", 64'(in_bus.ready), 64'd1);
    chk("mid_rst_wb_valid", 64'(wb_bus.valid), 64'd0);
    chk("mid_rst_count", 64'(count_o), 64'd0);
    chk("mid_rst_fflags", 64'(fflags_o), 64'd0);
    rst_ni = 1'b1;
    drive(1'b0, 32'h0, '0, 4'h0);
    tick();
    tick();

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
